// File: rtl/ycbcr422_packer.sv
// Packs a 4:4:4 Y/Cb/Cr pixel stream into 4:2:2 YUYV words {Cr, Y1, Cb, Y0}.
// It also tracks the word index within each line and keeps a sticky line-framing error flag.
module ycbcr422_packer #(
  parameter bit         AVG    = 1'b1,
  parameter int         WCNT_W = 11,
  parameter logic [7:0] PAD_Y  = 8'h10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic              in_sol,
  input  logic              in_eol,
  input  logic [7:0]        Y,
  input  logic [7:0]        Cb,
  input  logic [7:0]        Cr,
  output logic              out_valid,
  output logic [31:0]       out_data,
  output logic              out_sof,
  output logic              out_sol,
  output logic              out_eol,
  output logic [WCNT_W-1:0] out_wcnt,
  output logic              out_err
);

  typedef enum logic {EVEN, ODD} phase_t;

  phase_t              phase;
  logic [7:0]          y0, cb0, cr0;
  logic                sof0, sol0;
  logic [WCNT_W-1:0]   wcnt;
  logic                err_set;

  logic [7:0]          cb_pair, cr_pair;
  logic                even_px;
  logic [WCNT_W-1:0]   pad_idx;

  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    return 8'(({1'b0, a} + {1'b0, b} + 9'd1) >> 1);
  endfunction

  // A new line arriving while a pixel is held restarts pairing from that pixel.
  always_comb begin
    cb_pair = AVG ? avg8(cb0, Cb) : cb0;
    cr_pair = AVG ? avg8(cr0, Cr) : cr0;
    even_px = (phase == EVEN) || in_sol;
    pad_idx = in_sol ? '0 : wcnt;
  end

  // Framing errors are recorded into err_set first, so out_err rises the cycle after
  // the word that revealed the problem; that word itself still reports the old status.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= EVEN;
      y0        <= '0;
      cb0       <= '0;
      cr0       <= '0;
      sof0      <= 1'b0;
      sol0      <= 1'b0;
      wcnt      <= '0;
      err_set   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_sol   <= 1'b0;
      out_eol   <= 1'b0;
      out_wcnt  <= '0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_err   <= out_err | err_set;
      err_set   <= 1'b0;
      if (in_valid) begin
        if ((phase == ODD) && in_sol)
          err_set <= 1'b1;
        if (even_px) begin
          if (in_eol) begin
            out_valid <= 1'b1;
            out_data  <= {Cr, PAD_Y, Cb, Y};
            out_sof   <= in_sof;
            out_sol   <= in_sol;
            out_eol   <= 1'b1;
            out_wcnt  <= pad_idx;
            wcnt      <= '0;
            phase     <= EVEN;
            if (!in_sol)
              err_set <= 1'b1;
          end else begin
            y0    <= Y;
            cb0   <= Cb;
            cr0   <= Cr;
            sof0  <= in_sof;
            sol0  <= in_sol;
            phase <= ODD;
            if (in_sol)
              wcnt <= '0;
          end
        end else begin
          out_valid <= 1'b1;
          out_data  <= {cr_pair, Y, cb_pair, y0};
          out_sof   <= sof0;
          out_sol   <= sol0;
          out_eol   <= in_eol;
          out_wcnt  <= wcnt;
          wcnt      <= in_eol ? '0 : wcnt + WCNT_W'(1);
          phase     <= EVEN;
        end
      end
    end
  end

endmodule

// File: tb/tb_ycbcr422_packer.sv
// Bench for ycbcr422_packer: drives averaging and even-pixel-chroma instances with the same pixels.
// Every cycle is compared against a pixel-level reference model of the packing rules.
module tb_ycbcr422_packer;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic        sof;
    logic        sol;
    logic        eol;
    logic [10:0] wc;
    logic        err;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_sof = 1'b0, in_sol = 1'b0, in_eol = 1'b0;
  logic [7:0] Y = '0, Cb = '0, Cr = '0;

  logic a_valid, a_sof, a_sol, a_eol, a_err;
  logic [31:0] a_data;
  logic [10:0] a_wcnt;
  logic b_valid, b_sof, b_sol, b_eol, b_err;
  logic [31:0] b_data;
  logic [10:0] b_wcnt;

  int checks = 0;
  int failures = 0;

  // reference model state
  bit       m_pend;
  bit [7:0] m_y, m_cb, m_cr;
  bit       m_sof, m_sol;
  int       m_idx;
  bit       m_err;

  always #5 clk = ~clk;

  ycbcr422_packer #(.AVG(1'b1), .WCNT_W(11), .PAD_Y(8'h10)) u_avg (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_sol(in_sol),
    .in_eol(in_eol), .Y(Y), .Cb(Cb), .Cr(Cr), .out_valid(a_valid), .out_data(a_data),
    .out_sof(a_sof), .out_sol(a_sol), .out_eol(a_eol), .out_wcnt(a_wcnt), .out_err(a_err)
  );

  ycbcr422_packer #(.AVG(1'b0), .WCNT_W(11), .PAD_Y(8'h10)) u_sub (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_sol(in_sol),
    .in_eol(in_eol), .Y(Y), .Cb(Cb), .Cr(Cr), .out_valid(b_valid), .out_data(b_data),
    .out_sof(b_sof), .out_sol(b_sol), .out_eol(b_eol), .out_wcnt(b_wcnt), .out_err(b_err)
  );

  function automatic obs_t get_a();
    return {a_valid, a_data, a_sof, a_sol, a_eol, a_wcnt, a_err};
  endfunction

  function automatic obs_t get_b();
    return {b_valid, b_data, b_sof, b_sol, b_eol, b_wcnt, b_err};
  endfunction

  function automatic void model_reset();
    m_pend = 0; m_idx = 0; m_err = 0;
  endfunction

  // One clock: present a pixel (or a gap), advance the model, sample 1 time unit after the edge.
  // The error status seen after a cycle covers only pixels from earlier cycles.
  task automatic step(input bit v, input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                      input bit sof, input bit sol, input bit eol,
                      output obs_t o1, output obs_t o0, output obs_t e1, output obs_t e0);
    obs_t keep;
    in_valid = v; Y = y; Cb = cb; Cr = cr; in_sof = sof; in_sol = sol; in_eol = eol;
    e1 = '0;
    e1.err = m_err;
    e0 = e1;
    if (v) begin
      if (sol && m_pend) begin
        m_err = 1; m_pend = 0;
      end
      if (!m_pend) begin
        if (eol) begin
          if (!sol) m_err = 1;
          e1.v = 1; e1.d = {cr, 8'h10, cb, y};
          e1.sof = sof; e1.sol = sol; e1.eol = 1;
          e1.wc = sol ? 11'd0 : 11'(m_idx);
          e0 = e1;
          m_idx = 0;
        end else begin
          m_pend = 1; m_y = y; m_cb = cb; m_cr = cr; m_sof = sof; m_sol = sol;
          if (sol) m_idx = 0;
        end
      end else begin
        e1.v = 1; e1.sof = m_sof; e1.sol = m_sol; e1.eol = eol; e1.wc = 11'(m_idx);
        e0 = e1;
        e1.d = {8'((int'(m_cr) + int'(cr) + 1) / 2), y, 8'((int'(m_cb) + int'(cb) + 1) / 2), m_y};
        e0.d = {m_cr, y, m_cb, m_y};
        m_idx = eol ? 0 : (m_idx + 1) % 2048;
        m_pend = 0;
      end
    end
    @(posedge clk);
    #1;
    o1 = get_a();
    o0 = get_b();
    if (!e1.v) begin
      keep = '0; keep.v = 1'b1; keep.err = 1'b1;
      o1 = o1 & keep;
      o0 = o0 & keep;
    end
    in_valid = 0;
  endtask

  task automatic rnd_step(input bit v, input bit sof, input bit sol, input bit eol,
                          output obs_t o1, output obs_t o0, output obs_t e1, output obs_t e0);
    step(v, 8'($urandom), 8'($urandom), 8'($urandom), sof, sol, eol, o1, o0, e1, e0);
  endtask

  // Reset with a live pixel on the inputs; that pixel must be dropped.
  task automatic apply_reset();
    rst = 1; in_valid = 1; in_sof = 1; in_sol = 1; in_eol = 0;
    Y = 8'($urandom); Cb = 8'($urandom); Cr = 8'($urandom);
    @(posedge clk);
    #1;
    rst = 0; in_valid = 0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks += 2;
    if (get_a() !== '0) begin failures++; $display("FAIL reset_a got=%h exp=0", get_a()); end
    if (get_b() !== '0) begin failures++; $display("FAIL reset_b got=%h exp=0", get_b()); end
  endtask

  task automatic test_pair();
    obs_t o1, o0, e1, e0;
    step(1, 8'd16, 8'd128, 8'd128, 1, 1, 0, o1, o0, e1, e0);
    checks += 2;
    if (o1 !== e1) begin failures++; $display("FAIL pair_first_a got=%h exp=%h", o1, e1); end
    if (o0 !== e0) begin failures++; $display("FAIL pair_first_b got=%h exp=%h", o0, e0); end
    step(1, 8'd235, 8'd100, 8'd201, 0, 0, 1, o1, o0, e1, e0);
    checks += 4;
    if (o1 !== e1) begin failures++; $display("FAIL pair_word_a got=%h exp=%h", o1, e1); end
    if (o0 !== e0) begin failures++; $display("FAIL pair_word_b got=%h exp=%h", o0, e0); end
    if (o1.d !== 32'hA5EB7210) begin failures++; $display("FAIL pair_avg_data got=%h exp=a5eb7210", o1.d); end
    if (o0.d !== 32'h80EB8010) begin failures++; $display("FAIL pair_even_data got=%h exp=80eb8010", o0.d); end
  endtask

  task automatic test_line_gaps();
    obs_t o1, o0, e1, e0;
    int k;
    for (int ln = 0; ln < 2; ln++) begin
      k = 0;
      for (int p = 0; p < 8; p++) begin
        for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
          rnd_step(0, 1, 1, 1, o1, o0, e1, e0);
          checks += 2;
          if (o1 !== e1) begin failures++; $display("FAIL gap_idle_a got=%h exp=%h", o1, e1); end
          if (o0 !== e0) begin failures++; $display("FAIL gap_idle_b got=%h exp=%h", o0, e0); end
        end
        rnd_step(1, 0, p == 0, p == 7, o1, o0, e1, e0);
        checks += 2;
        if (o1 !== e1) begin failures++; $display("FAIL gap_px_a got=%h exp=%h", o1, e1); end
        if (o0 !== e0) begin failures++; $display("FAIL gap_px_b got=%h exp=%h", o0, e0); end
        if (o1.v) begin
          checks += 2;
          if (o1.wc !== 11'(k)) begin failures++; $display("FAIL gap_wcnt got=%0d exp=%0d", o1.wc, k); end
          if (o1.eol !== (k == 3)) begin failures++; $display("FAIL gap_eol got=%b exp=%b", o1.eol, k == 3); end
          k++;
        end
      end
      checks++;
      if (k !== 4) begin failures++; $display("FAIL gap_strobes got=%0d exp=4", k); end
    end
  endtask

  task automatic test_odd_eol();
    obs_t o1, o0, e1, e0;
    rnd_step(1, 0, 1, 0, o1, o0, e1, e0);
    rnd_step(1, 0, 0, 0, o1, o0, e1, e0);
    checks += 2;
    if (o1 !== e1) begin failures++; $display("FAIL odd_first_a got=%h exp=%h", o1, e1); end
    if (o0 !== e0) begin failures++; $display("FAIL odd_first_b got=%h exp=%h", o0, e0); end
    step(1, 8'h50, 8'h40, 8'hC0, 0, 0, 1, o1, o0, e1, e0);
    checks += 6;
    if (o1 !== e1) begin failures++; $display("FAIL odd_pad_a got=%h exp=%h", o1, e1); end
    if (o0 !== e0) begin failures++; $display("FAIL odd_pad_b got=%h exp=%h", o0, e0); end
    if (o1.d !== 32'hC0104050) begin failures++; $display("FAIL odd_pad_data got=%h exp=c0104050", o1.d); end
    if (o0.d !== 32'hC0104050) begin failures++; $display("FAIL odd_pad_data_b got=%h exp=c0104050", o0.d); end
    if (o1.eol !== 1'b1) begin failures++; $display("FAIL odd_pad_eol got=%b exp=1", o1.eol); end
    if (o1.err !== 1'b0) begin failures++; $display("FAIL odd_pad_err got=%b exp=0", o1.err); end
    rnd_step(0, 0, 0, 0, o1, o0, e1, e0);
    checks += 2;
    if (o1 !== e1) begin failures++; $display("FAIL odd_after_a got=%h exp=%h", o1, e1); end
    if (o0 !== e0) begin failures++; $display("FAIL odd_after_b got=%h exp=%h", o0, e0); end
  endtask

  task automatic test_sol_in_odd();
    obs_t o1, o0, e1, e0;
    rnd_step(1, 0, 1, 0, o1, o0, e1, e0);
    rnd_step(1, 0, 0, 1, o1, o0, e1, e0);
    rnd_step(1, 0, 1, 0, o1, o0, e1, e0);
    rnd_step(1, 0, 1, 0, o1, o0, e1, e0);
    rnd_step(1, 0, 0, 1, o1, o0, e1, e0);
    checks += 4;
    if (o1 !== e1) begin failures++; $display("FAIL restart_word_a got=%h exp=%h", o1, e1); end
    if (o0 !== e0) begin failures++; $display("FAIL restart_word_b got=%h exp=%h", o0, e0); end
    if (o1.wc !== 11'd0) begin failures++; $display("FAIL restart_wcnt got=%0d exp=0", o1.wc); end
    if (o1.sol !== 1'b1) begin failures++; $display("FAIL restart_sol got=%b exp=1", o1.sol); end
    for (int i = 0; i < 4; i++) begin
      rnd_step(0, 0, 0, 0, o1, o0, e1, e0);
      checks += 2;
      if (o1.err !== 1'b1) begin failures++; $display("FAIL restart_err_sticky got=%b exp=1", o1.err); end
      if (o0 !== e0) begin failures++; $display("FAIL restart_idle_b got=%h exp=%h", o0, e0); end
    end
  endtask

  task automatic test_reset_midpair();
    obs_t o1, o0, e1, e0;
    step(1, 8'hAA, 8'hBB, 8'hCC, 1, 1, 0, o1, o0, e1, e0);
    apply_reset();
    checks += 2;
    if (get_a() !== '0) begin failures++; $display("FAIL midpair_reset_a got=%h exp=0", get_a()); end
    if (get_b() !== '0) begin failures++; $display("FAIL midpair_reset_b got=%h exp=0", get_b()); end
    step(1, 8'h21, 8'h31, 8'h41, 1, 1, 0, o1, o0, e1, e0);
    step(1, 8'h22, 8'h33, 8'h43, 0, 0, 0, o1, o0, e1, e0);
    checks += 5;
    if (o1 !== e1) begin failures++; $display("FAIL midpair_word_a got=%h exp=%h", o1, e1); end
    if (o0 !== e0) begin failures++; $display("FAIL midpair_word_b got=%h exp=%h", o0, e0); end
    if (o1.d !== 32'h42223221) begin failures++; $display("FAIL midpair_data got=%h exp=42223221", o1.d); end
    if (o1.sof !== 1'b1) begin failures++; $display("FAIL midpair_sof got=%b exp=1", o1.sof); end
    if (o1.wc !== 11'd0) begin failures++; $display("FAIL midpair_wcnt got=%0d exp=0", o1.wc); end
    rnd_step(1, 0, 0, 0, o1, o0, e1, e0);
    rnd_step(1, 0, 0, 1, o1, o0, e1, e0);
    checks += 2;
    if (o1 !== e1) begin failures++; $display("FAIL midpair_end_a got=%h exp=%h", o1, e1); end
    if (o1.err !== 1'b0) begin failures++; $display("FAIL midpair_err got=%b exp=0", o1.err); end
  endtask

  task automatic test_extreme_chroma();
    obs_t o1, o0, e1, e0;
    step(1, 8'($urandom), 8'd255, 8'd0, 0, 1, 0, o1, o0, e1, e0);
    step(1, 8'($urandom), 8'd255, 8'd1, 0, 0, 1, o1, o0, e1, e0);
    checks += 4;
    if (o1 !== e1) begin failures++; $display("FAIL extreme_a got=%h exp=%h", o1, e1); end
    if (o0 !== e0) begin failures++; $display("FAIL extreme_b got=%h exp=%h", o0, e0); end
    if (o1.d[15:8] !== 8'hFF) begin failures++; $display("FAIL extreme_cb got=%h exp=ff", o1.d[15:8]); end
    if (o1.d[31:24] !== 8'h01) begin failures++; $display("FAIL extreme_cr got=%h exp=01", o1.d[31:24]); end
  endtask

  task automatic test_random();
    obs_t o1, o0, e1, e0;
    int len;
    bit drop_eol;
    for (int ln = 0; ln < 40; ln++) begin
      len = int'($urandom_range(1, 12));
      drop_eol = ($urandom_range(0, 9) == 0);
      for (int p = 0; p < len; p++) begin
        if ($urandom_range(0, 3) == 0) begin
          rnd_step(0, 1, 1, 1, o1, o0, e1, e0);
          checks += 2;
          if (o1 !== e1) begin failures++; $display("FAIL rand_idle_a got=%h exp=%h", o1, e1); end
          if (o0 !== e0) begin failures++; $display("FAIL rand_idle_b got=%h exp=%h", o0, e0); end
        end
        rnd_step(1, (p == 0) && (ln % 4 == 0), p == 0, (p == len - 1) && !drop_eol, o1, o0, e1, e0);
        checks += 2;
        if (o1 !== e1) begin failures++; $display("FAIL rand_px_a got=%h exp=%h", o1, e1); end
        if (o0 !== e0) begin failures++; $display("FAIL rand_px_b got=%h exp=%h", o0, e0); end
      end
    end
  endtask

  task automatic test_wrap();
    obs_t o1, o0, e1, e0;
    int k;
    k = 0;
    for (int p = 0; p < 4100; p++) begin
      rnd_step(1, 0, p == 0, p == 4099, o1, o0, e1, e0);
      checks += 2;
      if (o1 !== e1) begin failures++; $display("FAIL wrap_a got=%h exp=%h", o1, e1); end
      if (o0 !== e0) begin failures++; $display("FAIL wrap_b got=%h exp=%h", o0, e0); end
      if (o1.v) begin
        if (k == 2047 || k == 2048) begin
          checks++;
          if (o1.wc !== 11'(k % 2048))
            begin failures++; $display("FAIL wrap_wcnt got=%0d exp=%0d", o1.wc, k % 2048); end
        end
        k++;
      end
    end
    checks++;
    if (k !== 2050) begin failures++; $display("FAIL wrap_strobes got=%0d exp=2050", k); end
  endtask

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_pair();
    test_line_gaps();
    test_odd_eol();
    apply_reset();
    test_sol_in_odd();
    test_reset_midpair();
    test_extreme_chroma();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ycbcr422_packer.md
# ycbcr422_packer

Downstream stage of the RGB-to-YCbCr converter in the capture path. It takes one 8-bit 4:4:4 Y/Cb/Cr pixel per cycle, along with pixel-valid and line/frame markers aligned to the converter's output latency. It subsamples chroma horizontally to 4:2:2 and packs each pixel pair into one 32-bit YUYV word for the memory writer. It also tracks each word's position within the line and flags malformed line framing.

## Interface
Parameters:
- AVG, 1: 1 = chroma of a pair is the rounded mean of both pixels; 0 = chroma of the even pixel only.
- WCNT_W, 11: width of the per-line word index.
- PAD_Y, 8'h10: luma used for Y1 when a line ends on an unpaired pixel.

Ports:
- clk  in  1  pixel clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  Y/Cb/Cr/markers valid this cycle.
- in_sof  in  1  first pixel of frame; qualified by in_valid.
- in_sol  in  1  first pixel of line; qualified by in_valid. in_sof implies in_sol.
- in_eol  in  1  last pixel of line; qualified by in_valid.
- Y, Cb, Cr  in  8 each  converter outputs, unsigned.
- out_valid  out  1  out_data and flags valid; one-cycle strobe per word.
- out_data  out  32  {Cr, Y1, Cb, Y0}; Y0 is the even (first) pixel, in bits [7:0].
- out_sof  out  1  word contains the first pixel of a frame.
- out_sol  out  1  first word of the line.
- out_eol  out  1  last word of the line.
- out_wcnt  out  WCNT_W  word index within line; 0 on the out_sol word.
- out_err  out  1  sticky framing error.

## Operation
- State: phase (EVEN / ODD), a hold register (Y0, Cb0, Cr0, sof, sol), word counter, and error flag.
- EVEN, in_valid:
  - If in_eol is 0: latch the pixel into hold and go to ODD.
  - If in_eol is 1 (unpaired last pixel): emit a word immediately with Y1 = PAD_Y and chroma = that pixel's Cb/Cr (no averaging). Set out_eol. Stay in EVEN.
- ODD, in_valid, no in_sol: emit {Cr', Y, Cb', Y0}.
  - AVG=1: Cb' = (Cb0 + Cb + 1) >> 1, computed with a 9-bit sum, so there is no overflow and the result is always ≤ 255. Cr' is computed the same way.
  - AVG=0: Cb' = Cb0, Cr' = Cr0.
  - out_sof and out_sol come from the hold register. out_eol = in_eol. Return to EVEN.
- ODD, in_valid with in_sol (previous line ended without in_eol on the pair):
  - Discard the held pixel and set out_err.
  - Treat the current pixel as an EVEN pixel, including the eol case.
- in_eol on an emitted word: out_wcnt of the next word is 0.
- in_sol pixel: restarts the counter, so its word has out_wcnt = 0 regardless of history.
- out_wcnt increments by 1 per emitted word and wraps modulo 2^WCNT_W; wrapping is not an error.
- in_valid = 0: state holds; gaps inside a pair are allowed.
- Markers with in_valid = 0 are ignored.
- out_err is sticky and is cleared only by rst. It is also set by in_eol arriving in EVEN state on a pixel that is not also in_sol. Such a pixel is still emitted as a padded word.

## Timing
- Registered outputs. out_valid asserts the cycle after the in_valid cycle that completes a word, i.e. the ODD pixel or an unpaired eol pixel. Latency is 1 cycle from that pixel.
- Maximum output rate: one word per two input cycles, except a padded word, which can follow a paired word on consecutive cycles.
- out_data, out_wcnt and flags are held between strobes. out_sof, out_sol and out_eol are meaningful only while out_valid = 1.
- Reset (any cycle, including mid-pair):
  - Next cycle: out_valid = 0, out_data = 0, out_sof = out_sol = out_eol = 0, out_wcnt = 0, out_err = 0.
  - phase = EVEN; the held pixel is discarded.
- A pixel presented in the same cycle as rst is dropped.

## Test plan
- AVG=1, sol pixel (Y=16, Cb=128, Cr=128) then (Y=235, Cb=100, Cr=201, eol) -> one strobe 1 cycle after the second pixel. Required fields: out_data = 0xA5EB7210, out_sol = 1, out_eol = 1, out_wcnt = 0, out_err = 0.
- Same stimulus with AVG=0 -> out_data = 0x80EB8010.
- 8-pixel line with in_valid gaps of 0–3 cycles between pixels -> 4 strobes, out_wcnt = 0, 1, 2, 3. Only the last strobe has out_eol = 1. A following line restarts at 0.
- Line of 3 pixels, third pixel Y=0x50, Cb=0x40, Cr=0xC0 with eol -> second word = 0xC0104050 with out_eol = 1, out_err = 0.
- ODD state when a new in_sol arrives -> held pixel dropped, out_err = 1 and stays 1 until rst. The new line's first word has out_wcnt = 0.
- Reset asserted mid-pair, then a fresh sof/sol pair -> all outputs 0 after reset. No word contains the pre-reset pixel. First word has out_sof = 1, out_wcnt = 0.
- Extreme chroma with AVG=1: Cb 255/255 -> 255, and 0/1 -> 1 (rounding up).
